// File: rtl/imem_boot_pkg.sv
// Shared types and defaults for the instruction-memory boot controller.
// Holds the controller state encoding, halt causes and default sizing.
package imem_boot_pkg;

  localparam int DEPTH_DEFAULT      = 64;
  localparam int MAX_CYCLES_DEFAULT = 110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE        = 2'd0,
    HC_CORE_ERR    = 2'd1,
    HC_FETCH_FAULT = 2'd2,
    HC_TIMEOUT     = 2'd3
  } halt_cause_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH x 32 words, synchronous write, asynchronous read.
// Contents are not reset; the loader defines them.
module imem_ram
  import imem_boot_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams a program into instruction memory, runs the core
// with a watchdog cycle limit, and parks it in HALT with a recorded cause.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        start,
  input  logic        restart,
  output logic        core_reset,
  input  logic [31:0] pc_islemci,
  output logic [31:0] komut_islemci,
  input  logic        hata_islemci,
  output logic [1:0]  state,
  output logic        prog_loaded,
  output logic [1:0]  halt_cause,
  output logic [15:0] cyc_cnt
);

  localparam int AW = $clog2(DEPTH);

  state_e      r_state;
  halt_cause_e r_halt_cause;
  logic [AW-1:0] r_wptr;
  logic          r_core_reset;
  logic          r_prog_loaded;
  logic [15:0]   r_cyc_cnt;

  logic        w_accept;
  logic        w_addr_hi;
  logic        w_fault;
  logic [31:0] w_rdata;

  // Writes are gated by the registered state, so an async reset kills them at once.
  assign w_accept  = (r_state == ST_LOAD) && ld_valid;
  assign w_addr_hi = |pc_islemci[31:AW+2];
  assign w_fault   = (pc_islemci[1:0] != 2'b00) || w_addr_hi;

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wptr),
    .i_wdata (ld_data),
    .i_raddr (pc_islemci[AW+1:2]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_halt_cause  <= HC_NONE;
      r_wptr        <= '0;
      r_core_reset  <= 1'b0;
      r_prog_loaded <= 1'b0;
      r_cyc_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ld_valid) begin
            r_state       <= ST_LOAD;
            r_wptr        <= '0;
            r_prog_loaded <= 1'b0;
          end else if (start && r_prog_loaded) begin
            r_state      <= ST_RUN;
            r_cyc_cnt    <= '0;
            r_core_reset <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            r_wptr <= r_wptr + AW'(1);
            // A full memory ends the load even without ld_last; the rest is dropped.
            if (ld_last || (r_wptr == AW'(DEPTH - 1))) begin
              r_state       <= ST_RUN;
              r_prog_loaded <= 1'b1;
              r_cyc_cnt     <= '0;
              r_core_reset  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hata_islemci) begin
            r_state      <= ST_HALT;
            r_halt_cause <= HC_CORE_ERR;
            r_core_reset <= 1'b0;
          end else if (w_fault) begin
            r_state      <= ST_HALT;
            r_halt_cause <= HC_FETCH_FAULT;
            r_core_reset <= 1'b0;
          end else if (r_cyc_cnt == 16'(MAX_CYCLES - 1)) begin
            r_state      <= ST_HALT;
            r_halt_cause <= HC_TIMEOUT;
            r_core_reset <= 1'b0;
          end else if (r_cyc_cnt != 16'hFFFF) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end
        ST_HALT: begin
          if (restart) begin
            r_state      <= ST_IDLE;
            r_halt_cause <= HC_NONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ld_ready      = (r_state == ST_LOAD);
  assign komut_islemci = w_addr_hi ? 32'h0 : w_rdata;
  assign core_reset    = r_core_reset;
  assign state         = r_state;
  assign prog_loaded   = r_prog_loaded;
  assign halt_cause    = r_halt_cause;
  assign cyc_cnt       = r_cyc_cnt;

endmodule
